edge_output_streamer: RTL

EDGE_OUTPUT_STREAMER -- requirements
Module: edge_output_streamer

---
 rtl/edge_output_streamer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/edge_output_streamer.sv
// Streams one image of gradient results from the gradient memory out as an Avalon-ST packet.
// A 2-entry prefetch FIFO keeps one beat per cycle flowing with a single-cycle memory read latency.
module edge_output_streamer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int PIX_COUNT = 3844
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dataAvailable_i,
  output logic              memGrd_o,
  output logic [ADDR_W-1:0] memGaddr_o,
  input  logic [DATA_W-1:0] memGrdData_i,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [DATA_W-1:0] src_data_o,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic              outputSent_o,
  output logic              busy_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(PIX_COUNT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PIX_COUNT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic              dav_q, armed_q;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              infl_q, infl_d;
  logic              infl_sop_q, infl_sop_d;
  logic              infl_eop_q, infl_eop_d;
  logic [DATA_W-1:0] fdata_q [2];
  logic [DATA_W-1:0] fdata_d [2];
  logic [1:0]        fsop_q, fsop_d;
  logic [1:0]        feop_q, feop_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic       rise;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] pend;

  // armed_q blocks a level that is already high when reset releases from counting as a rise
  assign rise = dataAvailable_i & ~dav_q & armed_q;

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    infl_d     = 1'b0;
    infl_sop_d = infl_sop_q;
    infl_eop_d = infl_eop_q;
    fdata_d    = fdata_q;
    fsop_d     = fsop_q;
    feop_d     = feop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    src_valid_o = (occ_q != 2'd0);
    pop         = src_valid_o & src_ready_i;
    push        = infl_q;
    pend        = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    issue       = (state_q == STREAM) && (rd_cnt_q < TOTAL) && (pend < 3'd2);

    if (issue) begin
      rd_cnt_d   = rd_cnt_q + 1'b1;
      infl_d     = 1'b1;
      infl_sop_d = (rd_cnt_q == '0);
      infl_eop_d = (rd_cnt_q == LAST);
    end
    if (push) begin
      fdata_d[wr_ptr_q] = memGrdData_i;
      fsop_d[wr_ptr_q]  = infl_sop_q;
      feop_d[wr_ptr_q]  = infl_eop_q;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + 2'(push) - 2'(pop);

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = STREAM;
          rd_cnt_d = '0;
          occ_d    = '0;
          wr_ptr_d = 1'b0;
          rd_ptr_d = 1'b0;
        end
      end
      STREAM: begin
        if (pop && feop_q[rd_ptr_q]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        rd_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      dav_q      <= 1'b0;
      armed_q    <= 1'b0;
      rd_cnt_q   <= '0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      fdata_q[0] <= '0;
      fdata_q[1] <= '0;
      fsop_q     <= '0;
      feop_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      dav_q      <= dataAvailable_i;
      armed_q    <= armed_q | ~dataAvailable_i;
      rd_cnt_q   <= rd_cnt_d;
      infl_q     <= infl_d;
      infl_sop_q <= infl_sop_d;
      infl_eop_q <= infl_eop_d;
      fdata_q    <= fdata_d;
      fsop_q     <= fsop_d;
      feop_q     <= feop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign memGrd_o     = issue;
  assign memGaddr_o   = rd_cnt_q[ADDR_W-1:0];
  assign src_data_o   = src_valid_o ? fdata_q[rd_ptr_q] : '0;
  assign src_sop_o    = src_valid_o & fsop_q[rd_ptr_q];
  assign src_eop_o    = src_valid_o & feop_q[rd_ptr_q];
  assign outputSent_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);

endmodule
